// File: rtl/param_controller.sv
// Parameter/command controller: decodes inbound UART messages, keeps the run flag and the
// parameter channels, and merges all responses into one ordered FIFO. PARAM_READBACK_EN enables PARAM_RD.
module param_controller #(
  parameter int HDR_W      = 8,
  parameter int PAY_W      = 64,
  parameter int NUM_PARAMS = 4,
  parameter int RESP_DEPTH = 4,
  parameter logic [NUM_PARAMS*PAY_W-1:0] PARAM_DEFAULTS = '0
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        uart_in_avail,
  input  logic                        uart_in_full,
  output logic                        uart_in_req,
  input  logic [HDR_W+PAY_W-1:0]      uart_in_msg,
  input  logic                        uart_out_ready,
  output logic                        uart_out_req,
  output logic [HDR_W+PAY_W-1:0]      uart_out_msg,
  input  logic                        mem_valid,
  input  logic [PAY_W-1:0]            mem_received_num,
  output logic                        mem_ack,
  input  logic                        mem_overrun,
  output logic                        mem_replace_valid,
  output logic [PAY_W-1:0]            mem_replace_num,
  output logic [NUM_PARAMS*PAY_W-1:0] params,
  output logic                        run
);

  localparam int MSG_W = HDR_W + PAY_W;
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;

  localparam logic [HDR_W-1:0] H_SYS      = HDR_W'(8'h01);
  localparam logic [HDR_W-1:0] H_REP      = HDR_W'(8'h02);
  localparam logic [HDR_W-1:0] H_ACK      = HDR_W'(8'h80);
  localparam logic [HDR_W-1:0] H_RECV     = HDR_W'(8'h81);
  localparam logic [HDR_W-1:0] H_ERR_INV  = HDR_W'(8'hF0);
  localparam logic [HDR_W-1:0] H_ERR_RUN  = HDR_W'(8'hF1);
  localparam logic [HDR_W-1:0] H_ERR_FULL = HDR_W'(8'hF2);
  localparam logic [HDR_W-1:0] H_ERR_OVR  = HDR_W'(8'hF3);
`ifdef PARAM_READBACK_EN
  localparam logic [HDR_W-1:0] H_PVAL     = HDR_W'(8'h82);
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPTURE, S_EXEC} state_t;

  state_t             state_q;
  logic [MSG_W-1:0]   msg_q;
  logic               run_q;
  logic [PAY_W-1:0]   params_q [NUM_PARAMS];
  logic               ovr_prev_q, full_prev_q;
  logic               ovr_pend_q, full_pend_q;
  logic               mem_ack_q, uart_in_req_q, uart_out_req_q, mem_replace_valid_q;
  logic [MSG_W-1:0]   uart_out_msg_q;
  logic [PAY_W-1:0]   mem_replace_num_q;
  logic [MSG_W-1:0]   fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic ovr_edge, full_edge, ovr_want, full_want, mem_want, exec_want;
  logic pop, space, push;
  logic grant_ovr, grant_full, grant_mem, grant_exec;
  logic [HDR_W-1:0] hdr;
  logic [PAY_W-1:0] pay, echo;
  logic [IDX_W-1:0] idx;
  logic is_sys, is_rep, is_wr;
  logic [MSG_W-1:0] exec_resp, push_data;

  // A source counts as requesting on the very edge it rises, so it outranks a same-cycle RECEIVED_NUM.
  assign ovr_edge  = mem_overrun & ~ovr_prev_q;
  assign full_edge = uart_in_full & ~full_prev_q;
  assign ovr_want  = ovr_pend_q | ovr_edge;
  assign full_want = full_pend_q | full_edge;
  assign mem_want  = mem_valid & ~mem_ack_q;
  assign exec_want = (state_q == S_EXEC);

  assign pop   = (count_q != '0) & uart_out_ready;
  assign space = (count_q != CNT_W'(RESP_DEPTH)) | pop;

  assign grant_ovr  = space & ovr_want;
  assign grant_full = space & full_want & ~ovr_want;
  assign grant_mem  = space & mem_want & ~ovr_want & ~full_want;
  assign grant_exec = space & exec_want & ~ovr_want & ~full_want & ~mem_want;
  assign push       = grant_ovr | grant_full | grant_mem | grant_exec;

  assign hdr    = msg_q[HDR_W-1:0];
  assign pay    = msg_q[MSG_W-1:HDR_W];
  assign echo   = msg_q[PAY_W-1:0];
  assign idx    = msg_q[IDX_W-1:0];
  assign is_sys = (hdr == H_SYS);
  assign is_rep = (hdr == H_REP);
  assign is_wr  = (hdr[HDR_W-1:4] == (HDR_W-4)'(1)) && (32'(hdr[3:0]) < NUM_PARAMS);

  always_comb begin
    exec_resp = {echo, H_ERR_INV};
    if (is_sys || is_rep) begin
      exec_resp = {echo, H_ACK};
    end else if (is_wr) begin
      exec_resp = run_q ? {echo, H_ERR_RUN} : {echo, H_ACK};
    end
`ifdef PARAM_READBACK_EN
    else if ((hdr[HDR_W-1:4] == (HDR_W-4)'(2)) && (32'(hdr[3:0]) < NUM_PARAMS)) begin
      exec_resp = {params_q[idx], H_PVAL};
    end
`endif
  end

  always_comb begin
    push_data = exec_resp;
    if (grant_ovr)       push_data = {{PAY_W{1'b0}}, H_ERR_OVR};
    else if (grant_full) push_data = {{PAY_W{1'b0}}, H_ERR_FULL};
    else if (grant_mem)  push_data = {mem_received_num, H_RECV};
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q             <= S_IDLE;
      msg_q               <= '0;
      run_q               <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= PARAM_DEFAULTS[i*PAY_W +: PAY_W];
      ovr_prev_q          <= 1'b1;
      full_prev_q         <= 1'b1;
      ovr_pend_q          <= 1'b0;
      full_pend_q         <= 1'b0;
      mem_ack_q           <= 1'b0;
      uart_in_req_q       <= 1'b0;
      uart_out_req_q      <= 1'b0;
      uart_out_msg_q      <= '0;
      mem_replace_valid_q <= 1'b0;
      mem_replace_num_q   <= '0;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
    end else begin
      uart_in_req_q       <= 1'b0;
      mem_replace_valid_q <= 1'b0;
      mem_ack_q           <= grant_mem;
      uart_out_req_q      <= pop;
      if (pop) uart_out_msg_q <= fifo_mem[rd_ptr_q];
      ovr_prev_q  <= mem_overrun;
      full_prev_q <= uart_in_full;
      ovr_pend_q  <= ovr_want & ~grant_ovr;
      full_pend_q <= full_want & ~grant_full;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (uart_in_avail && space && !ovr_want && !full_want && !mem_want) begin
            state_q       <= S_REQ;
            uart_in_req_q <= 1'b1;
          end
        end
        S_REQ:     state_q <= S_CAPTURE;
        S_CAPTURE: begin
          msg_q   <= uart_in_msg;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // Side effects are applied only on the edge the response actually enters the FIFO.
          if (grant_exec) begin
            state_q <= S_IDLE;
            if (is_sys) run_q <= pay[0];
            if (is_rep) begin
              mem_replace_valid_q <= 1'b1;
              mem_replace_num_q   <= pay;
            end
            for (int i = 0; i < NUM_PARAMS; i++) begin
              if (is_wr && !run_q && (idx == IDX_W'(i))) params_q[i] <= pay;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (ovr_edge || full_edge) run_q <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_params
    assign params[gi*PAY_W +: PAY_W] = params_q[gi];
  end

  assign uart_in_req       = uart_in_req_q;
  assign uart_out_req      = uart_out_req_q;
  assign uart_out_msg      = uart_out_msg_q;
  assign mem_ack           = mem_ack_q;
  assign mem_replace_valid = mem_replace_valid_q;
  assign mem_replace_num   = mem_replace_num_q;
  assign run               = run_q;

endmodule

// File: tb/tb_param_controller.sv
// Randomized bench for param_controller: a sequential command model plus per-source response queues.
module tb_param_controller;
  localparam int HW = 8, PW = 64, NP = 4, DEPTH = 4, MW = HW + PW;
  localparam logic [NP*PW-1:0] DEFS = {64'h0000_CAFE_0000_0003, 64'h0000_BEEF_0000_0002,
                                       64'd5, 64'h1234_5678_0000_0000};
`ifdef PARAM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_reset, uart_in_avail, uart_in_full, uart_in_req, uart_out_ready, uart_out_req;
  logic [MW-1:0] uart_in_msg, uart_out_msg;
  logic mem_valid, mem_ack, mem_overrun, mem_replace_valid, run;
  logic [PW-1:0] mem_received_num, mem_replace_num;
  logic [NP*PW-1:0] params;

  always #5 clk = ~clk;

  param_controller #(.HDR_W(HW), .PAY_W(PW), .NUM_PARAMS(NP), .RESP_DEPTH(DEPTH),
                     .PARAM_DEFAULTS(DEFS)) dut (
    .clk(clk), .n_reset(n_reset), .uart_in_avail(uart_in_avail), .uart_in_full(uart_in_full),
    .uart_in_req(uart_in_req), .uart_in_msg(uart_in_msg), .uart_out_ready(uart_out_ready),
    .uart_out_req(uart_out_req), .uart_out_msg(uart_out_msg), .mem_valid(mem_valid),
    .mem_received_num(mem_received_num), .mem_ack(mem_ack), .mem_overrun(mem_overrun),
    .mem_replace_valid(mem_replace_valid), .mem_replace_num(mem_replace_num),
    .params(params), .run(run));

  int checks = 0, failures = 0;
  logic [MW-1:0] in_q[$], exp_cmd[$], exp_mem[$];
  logic [PW-1:0] mem_q[$], exp_repl[$];
  logic [HW-1:0] out_hdrs[$];
  logic [PW-1:0] m_params [NP];
  logic m_run, prev_ack;
  logic [MW-1:0] last_out;
  logic [NP*PW-1:0] defs_v;
  int req_cnt, rdy_mode;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: each command applied in arrival order against the spec's rules.
  task automatic model_cmd(input logic [MW-1:0] m);
    logic [HW-1:0] h;
    logic [PW-1:0] p, echo;
    h = m[HW-1:0];
    p = m[MW-1:HW];
    echo = m[PW-1:0];
    if (h == 8'h01) begin
      m_run = p[0];
      exp_cmd.push_back({echo, 8'h80});
    end else if (h == 8'h02) begin
      exp_repl.push_back(p);
      exp_cmd.push_back({echo, 8'h80});
    end else if (h >= 8'h10 && int'(h) < 16 + NP) begin
      if (m_run) exp_cmd.push_back({echo, 8'hF1});
      else begin
        m_params[int'(h) - 16] = p;
        exp_cmd.push_back({echo, 8'h80});
      end
    end else if (RB && h >= 8'h20 && int'(h) < 32 + NP) begin
      exp_cmd.push_back({m_params[int'(h) - 32], 8'h82});
    end else begin
      exp_cmd.push_back({echo, 8'hF0});
    end
  endtask

  task automatic send_cmd(input logic [MW-1:0] m);
    model_cmd(m);
    in_q.push_back(m);
    uart_in_avail = 1'b1;
  endtask

  task automatic send_mem(input logic [PW-1:0] n);
    mem_q.push_back(n);
    exp_mem.push_back({n, 8'h81});
    mem_valid = 1'b1;
    mem_received_num = mem_q[0];
  endtask

  function automatic logic [MW-1:0] rand_cmd();
    logic [HW-1:0] h;
    case ($urandom_range(0, 5))
      0: h = 8'h01;
      1: h = 8'h02;
      2: h = 8'h10 + 8'($urandom_range(0, 3));
      3: h = 8'h20 + 8'($urandom_range(0, 3));
      4: h = 8'h10 + 8'($urandom_range(4, 15));
      default: h = 8'($urandom);
    endcase
    return {$urandom, $urandom, h};
  endfunction

  task automatic step();
    @(negedge clk);
    if (uart_out_req) begin
      last_out = uart_out_msg;
      out_hdrs.push_back(uart_out_msg[HW-1:0]);
      $display("out hdr=%02h payload=%016h", uart_out_msg[HW-1:0], uart_out_msg[MW-1:HW]);
      if (uart_out_msg[HW-1:0] == 8'h81) begin
        check("recv_pending", exp_mem.size() != 0, 1'b1);
        if (exp_mem.size() != 0) check("recv_msg", uart_out_msg, exp_mem.pop_front());
      end else begin
        check("resp_pending", exp_cmd.size() != 0, 1'b1);
        if (exp_cmd.size() != 0) check("resp_msg", uart_out_msg, exp_cmd.pop_front());
      end
    end
    if (mem_replace_valid) begin
      check("repl_pending", exp_repl.size() != 0, 1'b1);
      if (exp_repl.size() != 0) check("repl_num", mem_replace_num, exp_repl.pop_front());
    end
    if (mem_ack) begin
      check("ack_gap", prev_ack, 1'b0);
      check("ack_src", mem_q.size() != 0, 1'b1);
      if (mem_q.size() != 0) void'(mem_q.pop_front());
    end
    prev_ack = mem_ack;
    if (uart_in_req) begin
      req_cnt++;
      check("req_src", in_q.size() != 0, 1'b1);
      if (in_q.size() != 0) uart_in_msg = in_q.pop_front();
    end
    uart_in_avail = (in_q.size() != 0);
    mem_valid = (mem_q.size() != 0);
    mem_received_num = mem_valid ? mem_q[0] : '0;
    uart_out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((in_q.size() + mem_q.size() + exp_cmd.size() + exp_mem.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", in_q.size() + mem_q.size() + exp_cmd.size() + exp_mem.size(), 0);
    repeat (4) step();
    check("repl_done", exp_repl.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] exp41;
    defs_v = DEFS;
    for (int i = 0; i < NP; i++) m_params[i] = defs_v[i*PW +: PW];
    m_run = 1'b0; prev_ack = 1'b0; req_cnt = 0; rdy_mode = 1; last_out = '0;
    n_reset = 1'b0; uart_in_avail = 1'b0; uart_in_full = 1'b1; uart_in_msg = '0;
    uart_out_ready = 1'b1; mem_valid = 1'b0; mem_received_num = '0; mem_overrun = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_run", run, 1'b0);
    check("rst_in_req", uart_in_req, 1'b0);
    check("rst_out_req", uart_out_req, 1'b0);
    check("rst_mem_ack", mem_ack, 1'b0);
    check("rst_repl_valid", mem_replace_valid, 1'b0);
    check("rst_repl_num", mem_replace_num, 0);
    for (int i = 0; i < NP; i++) check($sformatf("rst_ch%0d", i), params[i*PW +: PW], defs_v[i*PW +: PW]);
    n_reset = 1'b1;
    repeat (6) step();
    check("no_edge_at_release", out_hdrs.size(), 0);
    uart_in_full = 1'b0;

    // PARAM_RD channel 1 straight after reset
    send_cmd({64'h0, 8'h21});
    drain(200);
    exp41 = RB ? {64'd5, 8'h82} : {64'h21, 8'hF0};
    check("rd_ch1", last_out, exp41);

    // PARAM_WR channel 2 while stopped
    send_cmd({64'hDEAD, 8'h12});
    drain(200);
    check("wr_ch2", params[2*PW +: PW], 64'hDEAD);
    check("wr_ch2_resp", last_out, {64'h00DE_AD12, 8'h80});

    // start, then a write is refused
    send_cmd({64'h1, 8'h01});
    send_cmd({64'h9999, 8'h10});
    drain(200);
    check("run_set", run, 1'b1);
    check("ch0_kept", params[PW-1:0], defs_v[PW-1:0]);
    check("wr_run_hdr", last_out[HW-1:0], 8'hF1);

    // FIFO backpressure: fifth inbound message waits for the sink
    rdy_mode = 0; req_cnt = 0;
    for (int i = 0; i < 5; i++) send_cmd({$urandom, $urandom, 8'h02});
    repeat (40) step();
    check("req_while_full", req_cnt, 4);
    check("in_left", in_q.size(), 1);
    rdy_mode = 1;
    drain(300);
    check("req_after_ready", req_cnt, 5);

    // overrun and mem_valid rising together
    out_hdrs.delete();
    send_mem(64'h1111_2222);
    mem_overrun = 1'b1;
    m_run = 1'b0;
    exp_cmd.push_back({64'h0, 8'hF3});
    step();
    check("run_clr_ovr", run, 1'b0);
    drain(200);
    check("order0", out_hdrs.size() > 0 ? out_hdrs[0] : 8'h00, 8'hF3);
    check("order1", out_hdrs.size() > 1 ? out_hdrs[1] : 8'h00, 8'h81);
    mem_overrun = 1'b0;

    // inbound-full edge stops the system, one error only while held
    send_cmd({64'h1, 8'h01});
    drain(200);
    check("run_set2", run, 1'b1);
    uart_in_full = 1'b1;
    m_run = 1'b0;
    exp_cmd.push_back({64'h0, 8'hF2});
    step();
    check("run_clr_full", run, 1'b0);
    drain(200);
    repeat (10) step();
    uart_in_full = 1'b0;

    // randomized mix of commands, memory numbers and sink stalls
    rdy_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      if (in_q.size() < 3 && $urandom_range(0, 2) == 0) send_cmd(rand_cmd());
      if (mem_q.size() < 2 && $urandom_range(0, 5) == 0) send_mem({$urandom, $urandom});
      step();
    end
    rdy_mode = 1;
    drain(3000);
    check("final_run", run, m_run);
    for (int i = 0; i < NP; i++) check($sformatf("final_ch%0d", i), params[i*PW +: PW], m_params[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_controller.md
PARAM_CONTROLLER -- requirements
Module: param_controller

Interface
REQ-001 SHALL have parameter HDR_W, default 8, header width in bits.
REQ-002 SHALL have parameter PAY_W, default 64, payload width in bits.
REQ-003 SHALL have parameter NUM_PARAMS, default 4, number of parameter channels (1..16).
REQ-004 SHALL have parameter RESP_DEPTH, default 4, response FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameter PARAM_DEFAULTS, default 0, NUM_PARAMS*PAY_W reset values, channel k at bits [k*PAY_W +: PAY_W].
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port uart_in_avail  input  1  inbound message waiting.
REQ-009 SHALL have port uart_in_full  input  1  inbound FIFO full (error source).
REQ-010 SHALL have port uart_in_req  output  1  one-cycle request for the next inbound message.
REQ-011 SHALL have port uart_in_msg  input  HDR_W+PAY_W  {payload, header}, header in LSBs.
REQ-012 SHALL have port uart_out_ready  input  1  outbound sink can accept.
REQ-013 SHALL have port uart_out_req  output  1  one-cycle write strobe for uart_out_msg.
REQ-014 SHALL have port uart_out_msg  output  HDR_W+PAY_W  outbound {payload, header}.
REQ-015 SHALL have port mem_valid  input  1  level; mem_received_num valid, held until mem_ack.
REQ-016 SHALL have port mem_received_num  input  PAY_W  number to report.
REQ-017 SHALL have port mem_ack  output  1  one-cycle acknowledge of mem_valid.
REQ-018 SHALL have port mem_overrun  input  1  memory overrun (error source).
REQ-019 SHALL have port mem_replace_valid  output  1  one-cycle strobe qualifying mem_replace_num.
REQ-020 SHALL have port mem_replace_num  output  PAY_W  replacement number.
REQ-021 SHALL have port params  output  NUM_PARAMS*PAY_W  parameter channel registers.
REQ-022 SHALL have port run  output  1  system run enable.

Function
REQ-023 SHALL decode headers: 0x01 SYS_STATUS, 0x02 REPLACE_NUM, 0x10+k PARAM_WR, 0x20+k PARAM_RD (k<NUM_PARAMS); all others invalid.
REQ-024 SHALL emit headers: 0x80 ACK, 0x81 RECEIVED_NUM, 0x82 PARAM_VALUE, 0xF0 ERR_INVALID_MSG, 0xF1 ERR_UPDATE_WHILST_RUN, 0xF2 ERR_FIFO_FULL, 0xF3 ERR_MEM_OVERRUN.
REQ-025 SHALL run FSM IDLE->REQ->CAPTURE->EXEC->IDLE: REQ asserts uart_in_req one cycle; CAPTURE samples uart_in_msg on the following edge; EXEC applies the message and pushes exactly one response.
REQ-026 SHALL leave IDLE for REQ only when uart_in_avail=1, the response FIFO has >=1 free entry and no higher-priority push is pending.
REQ-027 SHALL, for ACK and ERR_INVALID_MSG/ERR_UPDATE_WHILST_RUN, carry the received message's LSBs (PAY_W bits of {payload, header}) as response payload.
REQ-028 SHALL in EXEC: SYS_STATUS sets run=payload[0]; REPLACE_NUM pulses mem_replace_valid with mem_replace_num=payload (allowed while running); PARAM_WR loads channel k if run=0, else ERR_UPDATE_WHILST_RUN and channel unchanged.
REQ-029 SHALL, for PARAM_RD k, respond PARAM_VALUE with payload = channel k, regardless of run.
REQ-030 SHALL pulse mem_ack one cycle when mem_valid=1 and FIFO not full, pushing {mem_received_num, RECEIVED_NUM} that cycle; mem_ack SHALL be 0 the next cycle.
REQ-031 SHALL detect rising edges of mem_overrun and uart_in_full, clear run on the cycle after the edge, and set a sticky pending flag per source; each pending flag pushes one response with payload 0 when FIFO has space.
REQ-032 SHALL arbitrate FIFO pushes, one per cycle: ERR_MEM_OVERRUN > ERR_FIFO_FULL > RECEIVED_NUM > EXEC response; EXEC stalls in place until it wins.
REQ-033 SHALL pop the FIFO and pulse uart_out_req when non-empty and uart_out_ready=1, uart_out_msg = head, in order; push and pop in the same cycle when full SHALL be legal.
REQ-034 SHALL never drop or duplicate a response; FIFO full SHALL only stall sources.

Reset
REQ-035 SHALL on n_reset=0 asynchronously set: FSM IDLE, FIFO empty, pending flags 0, run=0, params=PARAM_DEFAULTS, uart_in_req/uart_out_req/mem_ack/mem_replace_valid=0, mem_replace_num=0, edge detectors loaded as 1 (level already high at release is not an edge); reset mid-transaction abandons it.

Configuration
REQ-036 SHALL, with PARAM_READBACK_EN defined, implement PARAM_RD; without it, 0x20+k SHALL be invalid (ERR_INVALID_MSG) and no readback mux SHALL exist.

Verification
REQ-037 PARAM_WR header 0x12 payload 0xDEAD with run=0 -> channel 2=0xDEAD, response {0x..DEAD12, 0x80}.
REQ-038 SYS_STATUS payload 1, then PARAM_WR 0x10 -> run=1, channel 0 unchanged, response header 0xF1.
REQ-039 uart_out_ready=0, five REPLACE_NUM with RESP_DEPTH=4 -> four accepted, fifth not requested until ready=1, then five ACKs in order.
REQ-040 mem_valid and mem_overrun rise same cycle with run=1 -> run=0, output order 0xF3 then 0x81.
REQ-041 PARAM_RD 0x21 after reset with PARAM_DEFAULTS channel1=5 -> {5, 0x82}; without PARAM_READBACK_EN -> header 0xF0.
